// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator.
// Holds the default data/packet/accumulator widths, the packet field
// positions and the result-packet layout for the default configuration.
package psum_accumulator_pkg;

   localparam int unsigned DWIDTH_DEF = 8;
   localparam int unsigned PWIDTH_DEF = 47;
   localparam int unsigned AWIDTH_DEF = 12;

   // Output-index field, shared by input and result packets
   localparam int unsigned IDX_MSB = 46;
   localparam int unsigned IDX_LSB = 40;
   localparam int unsigned IDX_W   = IDX_MSB - IDX_LSB + 1;

   // Result packet at default widths: {idx, reserved zeros, spike, value}
   typedef struct packed {
      logic [IDX_W-1:0]                        idx;
      logic [PWIDTH_DEF-IDX_W-AWIDTH_DEF-2:0]  rsvd;
      logic                                    spike;
      logic [AWIDTH_DEF-1:0]                   value;
   } result_pkt_t;

endpackage

// File: rtl/psum_accumulator_bank.sv
// psum_acc_bank: per-output-index accumulator and pass-count storage.
// One combinational-read / registered-write port sharing a single index,
// so the parent can do a read-modify-write in one cycle.
//   clk       : clock
//   clr_i     : synchronous clear of every entry
//   idx_i     : entry selected for read and write
//   rd_acc_o  : accumulator of the selected entry
//   rd_cnt_o  : pass count of the selected entry
//   we_i      : write the selected entry this edge
//   wr_acc_i  : new accumulator value
//   wr_cnt_i  : new pass count
module psum_acc_bank #(
   parameter int unsigned NUM_OUT = 25,
   parameter int unsigned AWIDTH  = 12,
   parameter int unsigned CWIDTH  = 3,
   parameter int unsigned BW      = 5
) (
   input  logic              clk,
   input  logic              clr_i,
   input  logic [BW-1:0]     idx_i,
   output logic [AWIDTH-1:0] rd_acc_o,
   output logic [CWIDTH-1:0] rd_cnt_o,
   input  logic              we_i,
   input  logic [AWIDTH-1:0] wr_acc_i,
   input  logic [CWIDTH-1:0] wr_cnt_i
);

   logic [AWIDTH-1:0] acc_q [NUM_OUT];
   logic [CWIDTH-1:0] cnt_q [NUM_OUT];
   logic              idx_ok;

   // BW bits can address more than NUM_OUT entries; unused codes read as 0
   assign idx_ok   = (32'(idx_i) < NUM_OUT);
   assign rd_acc_o = idx_ok ? acc_q[idx_i] : '0;
   assign rd_cnt_o = idx_ok ? cnt_q[idx_i] : '0;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int unsigned i = 0; i < NUM_OUT; i++) begin
            acc_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else if (we_i && idx_ok) begin
         acc_q[idx_i] <= wr_acc_i;
         cnt_q[idx_i] <= wr_cnt_i;
      end
   end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: collects PASSES partial sums per output pixel, emits
// a thresholded result packet per pixel and pulses at the end of a frame.
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : sum packet offered upstream
//   in_ready   : packet accepted this cycle
//   in_data    : [46:40] index, [DWIDTH-1:0] partial sum
//   out_valid  : result packet valid
//   out_ready  : downstream accepts result
//   out_data   : [46:40] index, [AWIDTH] spike, [AWIDTH-1:0] value
//   frame_done : one-cycle pulse after the NUM_OUT-th accepted result
//   idx_err    : sticky, set by an out-of-range index
module psum_accumulator
   import psum_accumulator_pkg::*;
#(
   parameter int unsigned DWIDTH  = DWIDTH_DEF,
   parameter int unsigned PWIDTH  = PWIDTH_DEF,
   parameter int unsigned NUM_OUT = 25,
   parameter int unsigned PASSES  = 5,
   parameter int unsigned AWIDTH  = AWIDTH_DEF,
   parameter int unsigned THRESH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PWIDTH-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PWIDTH-1:0] out_data,
   output logic              frame_done,
   output logic              idx_err
);

   localparam int unsigned CWIDTH = $clog2(PASSES + 1);
   localparam int unsigned BW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   logic [IDX_W-1:0]  idx;
   logic [DWIDTH-1:0] psum;
   logic              xfer, in_range, we, complete, spike;
   logic [AWIDTH-1:0] rd_acc, wr_acc, sum_sat;
   logic [AWIDTH:0]   sum_wide;
   logic [CWIDTH-1:0] rd_cnt, wr_cnt, cnt_inc;

   logic              out_valid_q, out_valid_d;
   logic [PWIDTH-1:0] out_data_q, out_data_d;
   logic              frame_done_q, frame_done_d;
   logic              idx_err_q, idx_err_d;
   logic [BW-1:0]     frame_q, frame_d;

   logic              unused_in_bits;
   assign unused_in_bits = ^in_data[IDX_LSB-1:DWIDTH];

   assign idx      = in_data[IDX_MSB:IDX_LSB];
   assign psum     = in_data[DWIDTH-1:0];
   assign in_ready = !out_valid_q || out_ready;
   assign xfer     = in_valid && in_ready;
   assign in_range = ({1'b0, idx} < (IDX_W + 1)'(NUM_OUT));
   assign we       = xfer && in_range;

   psum_acc_bank #(
      .NUM_OUT (NUM_OUT),
      .AWIDTH  (AWIDTH),
      .CWIDTH  (CWIDTH),
      .BW      (BW)
   ) u_bank (
      .clk      (clk),
      .clr_i    (!rst_n),
      .idx_i    (idx[BW-1:0]),
      .rd_acc_o (rd_acc),
      .rd_cnt_o (rd_cnt),
      .we_i     (we),
      .wr_acc_i (wr_acc),
      .wr_cnt_i (wr_cnt)
   );

   // Read-modify-write: the completing pass clears the entry in the same edge
   always_comb begin
      sum_wide = {1'b0, rd_acc} + (AWIDTH + 1)'(psum);
      sum_sat  = sum_wide[AWIDTH] ? '1 : sum_wide[AWIDTH-1:0];
      cnt_inc  = rd_cnt + CWIDTH'(1);
      complete = (cnt_inc == CWIDTH'(PASSES));
      spike    = (32'(sum_sat) >= THRESH);
      wr_acc   = complete ? '0 : sum_sat;
      wr_cnt   = complete ? '0 : cnt_inc;
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      frame_d      = frame_q;
      frame_done_d = 1'b0;
      idx_err_d    = idx_err_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         if (frame_q == BW'(NUM_OUT - 1)) begin
            frame_d      = '0;
            frame_done_d = 1'b1;
         end else begin
            frame_d = frame_q + BW'(1);
         end
      end

      // A new result may be loaded on the same edge the old one is accepted
      if (we && complete) begin
         out_valid_d                    = 1'b1;
         out_data_d                     = '0;
         out_data_d[IDX_MSB:IDX_LSB]    = idx;
         out_data_d[AWIDTH]             = spike;
         out_data_d[AWIDTH-1:0]         = sum_sat;
      end

      if (xfer && !in_range) begin
         idx_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         frame_q      <= '0;
         frame_done_q <= 1'b0;
         idx_err_q    <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         frame_q      <= frame_d;
         frame_done_q <= frame_done_d;
         idx_err_q    <= idx_err_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign frame_done = frame_done_q;
   assign idx_err    = idx_err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;
   import psum_accumulator_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, frame_done, idx_err;
   logic [46:0] in_data, out_data;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_frame_done, s_idx_err;
   logic [46:0] s_in_data, s_out_data;

   always #5 clk = ~clk;

   psum_accumulator dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .frame_done(frame_done), .idx_err(idx_err)
   );

   psum_accumulator #(.AWIDTH(8)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_data(s_out_data), .frame_done(s_frame_done), .idx_err(s_idx_err)
   );

   int checks = 0;
   int failures = 0;
   int accepts = 0;
   int fd_pulses = 0;

   typedef struct {
      logic [6:0]  idx;
      logic [11:0] value;
      logic        spike;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [6:0]  idx;
      logic [7:0]  ps;
      logic        emit;
      logic [11:0] value;
      logic        spike;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [46:0] mk_pkt(input logic [6:0] idx, input logic [11:0] value,
                                          input logic spike);
      result_pkt_t p;
      p       = '0;
      p.idx   = idx;
      p.value = value;
      p.spike = spike;
      return p;
   endfunction

   task automatic expect_out(input int idx, input int value, input logic spike);
      exp_t e;
      e.idx   = 7'(idx);
      e.value = 12'(value);
      e.spike = spike;
      sb.push_back(e);
   endtask

   task automatic addv(input int idx, input int ps, input logic emit, input int value,
                       input logic spike);
      vec_t v;
      v.idx = 7'(idx); v.ps = 8'(ps); v.emit = emit; v.value = 12'(value); v.spike = spike;
      tbl.push_back(v);
   endtask

   // Drives one packet with random filler in the ignored bits; bounded wait for in_ready
   task automatic send(input int idx, input int ps);
      int unsigned n;
      in_data        = '0;
      in_data[39:8]  = $urandom;
      in_data[46:40] = 7'(idx);
      in_data[7:0]   = 8'(ps);
      in_valid       = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Scoreboard: every accepted result is popped and compared
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%0h required=none", out_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_out_data", 64'(out_data), 64'(mk_pkt(e.idx, e.value, e.spike)));
         end
         accepts++;
      end
      if (frame_done) begin
         fd_pulses++;
         chk("frame_done_at_accept", 64'(accepts), 64'd25);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [46:0] held, e;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;

      // Vector table: single-index sums, readback of cleared entry, interleave
      addv(3, 10, 0, 0, 0); addv(3, 20, 0, 0, 0); addv(3, 5, 0, 0, 0);
      addv(3, 15, 0, 0, 0); addv(3, 14, 1, 64, 1);
      for (int i = 0; i < 4; i++) addv(7, 12, 0, 0, 0);
      addv(7, 12, 1, 60, 0);
      for (int i = 0; i < 4; i++) addv(7, 1, 0, 0, 0);
      addv(7, 1, 1, 5, 0);
      for (int i = 0; i < 4; i++) begin addv(1, 255, 0, 0, 0); addv(2, 255, 0, 0, 0); end
      addv(1, 255, 1, 1275, 1); addv(2, 255, 1, 1275, 1);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_idx_err", 64'(idx_err), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;

      foreach (tbl[k]) begin
         if (tbl[k].emit) expect_out(int'(tbl[k].idx), int'(tbl[k].value), tbl[k].spike);
         send(int'(tbl[k].idx), int'(tbl[k].ps));
         chk("tbl_out_valid", 64'(out_valid), 64'(tbl[k].emit));
         if (tbl[k].emit)
            chk("tbl_out_data", 64'(out_data), 64'(mk_pkt(tbl[k].idx, tbl[k].value, tbl[k].spike)));
      end

      // Backpressure: pending result blocks a completing transfer
      for (int i = 0; i < 4; i++) send(5, 3);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(4, 2);
      expect_out(4, 10, 0);
      send(4, 2);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      held = out_data;
      chk("bp_held_data", 64'(held), 64'(mk_pkt(7'd4, 12'd10, 1'b0)));
      in_data = '0; in_data[46:40] = 7'd5; in_data[7:0] = 8'd3; in_valid = 1'b1;
      expect_out(5, 15, 0);
      for (int i = 0; i < 4; i++) begin
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
         chk("bp_out_stable", 64'(out_data), 64'(held));
         chk("bp_valid_stable", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_second_valid", 64'(out_valid), 64'd1);
      chk("bp_second_data", 64'(out_data), 64'(mk_pkt(7'd5, 12'd15, 1'b0)));
      @(posedge clk); #1;
      chk("bp_drop_valid", 64'(out_valid), 64'd0);

      // Out-of-range index: flag only, no output, no aliasing into the bank
      send(30, 99);
      chk("oor_idx_err", 64'(idx_err), 64'd1);
      chk("oor_no_output", 64'(out_valid), 64'd0);
      send(3, 1); send(3, 1);
      send(35, 99);
      chk("oor_no_output2", 64'(out_valid), 64'd0);
      send(3, 1); send(3, 1);
      expect_out(3, 5, 0);
      send(3, 1);
      chk("oor_clean_sum", 64'(out_data), 64'(mk_pkt(7'd3, 12'd5, 1'b0)));
      chk("oor_sticky", 64'(idx_err), 64'd1);
      @(posedge clk); #1;

      // Reset mid-accumulation and with a result pending
      for (int i = 0; i < 3; i++) send(0, 7);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(6, 20);
      chk("prerst_pending", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sb.delete();
      accepts = 0;
      rst_n = 1'b1;
      out_ready = 1'b1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_data", 64'(out_data), 64'd0);
      chk("midrst_idx_err", 64'(idx_err), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);

      // Full frame; idx 0 passes of 1 prove the pre-reset partials were dropped
      for (int i = 0; i < 25; i++) begin
         for (int p = 0; p < 5; p++) begin
            if (p == 4) expect_out(i, 5 * (i + 1), (5 * (i + 1)) >= 64);
            send(i, i + 1);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      chk("frame_accepts", 64'(accepts), 64'd25);
      chk("frame_done_pulses", 64'(fd_pulses), 64'd1);
      for (int p = 0; p < 4; p++) send(9, 2);
      expect_out(9, 10, 0);
      send(9, 2);
      repeat (3) @(posedge clk);
      #1;
      chk("frame_wrap_no_pulse", 64'(fd_pulses), 64'd1);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      // Saturation with an 8-bit accumulator
      s_in_data = '0; s_in_data[46:40] = 7'd2; s_in_data[7:0] = 8'd255; s_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("sat_in_ready", 64'(s_in_ready), 64'd1);
         chk("sat_no_early_out", 64'(s_out_valid), 64'd0);
         @(posedge clk); #1;
      end
      s_in_valid = 1'b0;
      e = '0; e[46:40] = 7'd2; e[8] = 1'b1; e[7:0] = 8'hFF;
      chk("sat_out_valid", 64'(s_out_valid), 64'd1);
      chk("sat_out_data", 64'(s_out_data), 64'(e));
      @(posedge clk); #1;
      chk("sat_out_drop", 64'(s_out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
